wb_arbiter: RTL and testbench



---
 rtl/wb_arbiter_pkg.sv | 20 ++
 rtl/wb_arb_watchdog.sv | 35 +++
 rtl/wb_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_wb_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types for the two-master Wishbone arbiter.
// Contents: arbiter state encoding, master index constants and a helper
// that maps a master index to its BUSY state.
package wb_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_M0 = 2'd1,
    BUSY_M1 = 2'd2
  } arb_state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // BUSY state that serves master m
  function automatic arb_state_t busy_state(logic m);
    return (m == M1) ? BUSY_M1 : BUSY_M0;
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Bus watchdog for wb_arbiter: counts granted cycles without an ack and
// flags the cycle on which the transfer has to be terminated.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   busy          arbiter is in a BUSY state
//   clr           current transfer ends this cycle (ack, abort or expiry)
//   expire_c      combinational: counter has reached TIMEOUT-1 while busy
module wb_arb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic busy,
  input  logic clr,
  output logic expire_c
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Counts cycles of the current transfer; zero whenever idle or restarting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (busy && !clr) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= '0;
    end
  end

  assign expire_c = busy && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_arbiter.sv
// Two-master, one-slave Wishbone arbiter with per-transfer round-robin.
// Master 0 is the CPU, master 1 a DMA/debug master. The grant is registered
// (one cycle of arbitration latency); once granted, the master's signals are
// muxed combinationally to the slave and the slave's response back.
// Optional build macro WB_ARB_TIMEOUT_EN adds a watchdog that ends a hung
// transfer with mx_err after TIMEOUT cycles; without it mx_err is tied low.
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   mX_cyc/stb/we/lock/adr/dat_o       master X request (X = 0, 1)
//   mX_dat_i/ack/err                   response to master X
//   s_cyc/stb/we/adr/dat_o             request to slave
//   s_dat_i, s_ack                     response from slave
//   gnt                                one-hot grant (bit X = master X)
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          m0_cyc,
  input  logic          m0_stb,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_dat_o,
  output logic [DW-1:0] m0_dat_i,
  output logic          m0_ack,
  output logic          m0_err,
  input  logic          m1_cyc,
  input  logic          m1_stb,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_dat_o,
  output logic [DW-1:0] m1_dat_i,
  output logic          m1_ack,
  output logic          m1_err,
  output logic          s_cyc,
  output logic          s_stb,
  output logic          s_we,
  output logic [AW-1:0] s_adr,
  output logic [DW-1:0] s_dat_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack,
  output logic [1:0]    gnt
);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("wb_arbiter: TIMEOUT must be at least 2");
  end

  arb_state_t state, state_nxt;
  logic       last_m, last_m_nxt;

  logic          req0, req1;
  logic          busy, cur_m;
  logic          cur_cyc, cur_stb, cur_we, cur_lock;
  logic [AW-1:0] cur_adr;
  logic [DW-1:0] cur_dat;
  logic          req_cur, req_oth;
  logic          abort, timeout;

  assign req0 = m0_cyc & m0_stb;
  assign req1 = m1_cyc & m1_stb;

  // Signals of the currently granted master
  assign busy     = (state != IDLE);
  assign cur_m    = (state == BUSY_M1) ? M1 : M0;
  assign cur_cyc  = (cur_m == M1) ? m1_cyc   : m0_cyc;
  assign cur_stb  = (cur_m == M1) ? m1_stb   : m0_stb;
  assign cur_we   = (cur_m == M1) ? m1_we    : m0_we;
  assign cur_lock = (cur_m == M1) ? m1_lock  : m0_lock;
  assign cur_adr  = (cur_m == M1) ? m1_adr   : m0_adr;
  assign cur_dat  = (cur_m == M1) ? m1_dat_o : m0_dat_o;
  assign req_cur  = (cur_m == M1) ? req1 : req0;
  assign req_oth  = (cur_m == M1) ? req0 : req1;

  // Master dropped cyc before the slave answered
  assign abort = busy & ~s_ack & ~cur_cyc;

`ifdef WB_ARB_TIMEOUT_EN
  logic wd_expire;

  wb_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset_n  (reset_n),
    .busy     (busy),
    .clr      (s_ack | abort | timeout),
    .expire_c (wd_expire)
  );

  // An abort in the same cycle wins: nothing is left to terminate
  assign timeout = wd_expire & ~s_ack & cur_cyc;
`else
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      last_m <= M1;
    end else begin
      state  <= state_nxt;
      last_m <= last_m_nxt;
    end
  end

  // Next state and priority pointer
  always_comb begin
    state_nxt  = state;
    last_m_nxt = last_m;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          state_nxt = busy_state(~last_m);
        end else if (req0) begin
          state_nxt = BUSY_M0;
        end else if (req1) begin
          state_nxt = BUSY_M1;
        end
      end
      BUSY_M0, BUSY_M1: begin
        if (s_ack || timeout) begin
          // Transfer end: locked master keeps the bus, else round-robin
          last_m_nxt = cur_m;
          if (cur_lock && req_cur) begin
            state_nxt = state;
          end else if (req_oth) begin
            state_nxt = busy_state(~cur_m);
          end else if (req_cur) begin
            state_nxt = state;
          end else begin
            state_nxt = IDLE;
          end
        end else if (abort) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus mux; everything is zero while idle or in reset
  always_comb begin
    gnt      = 2'b00;
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_o  = '0;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m0_dat_i = '0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    m1_dat_i = '0;
    if (busy) begin
      s_cyc   = cur_cyc & ~timeout;
      s_stb   = cur_stb & ~timeout;
      s_we    = cur_we;
      s_adr   = cur_adr;
      s_dat_o = cur_dat;
      if (cur_m == M1) begin
        gnt      = 2'b10;
        m1_ack   = s_ack;
        m1_err   = timeout;
        m1_dat_i = s_dat_i;
      end else begin
        gnt      = 2'b01;
        m0_ack   = s_ack;
        m0_err   = timeout;
        m0_dat_i = s_dat_i;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, hand-written
// corner sequences and a randomized run against a transfer-level model.
module tb_wb_arbiter;

  localparam int unsigned OW      = 73;
  localparam int unsigned TB_TO   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [1:0]  mcyc, mstb, mwe, mlock;
  logic [15:0] madr [2];
  logic [15:0] mdat [2];
  logic [15:0] s_dat_i;
  logic        s_ack;

  logic [15:0] m0_dat_i, m1_dat_i, s_adr, s_dat_o;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [1:0]  gnt;

  wb_arbiter #(.AW(16), .DW(16), .TIMEOUT(TB_TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_cyc(mcyc[0]), .m0_stb(mstb[0]), .m0_we(mwe[0]), .m0_lock(mlock[0]),
    .m0_adr(madr[0]), .m0_dat_o(mdat[0]), .m0_dat_i(m0_dat_i),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(mcyc[1]), .m1_stb(mstb[1]), .m1_we(mwe[1]), .m1_lock(mlock[1]),
    .m1_adr(madr[1]), .m1_dat_o(mdat[1]), .m1_dat_i(m1_dat_i),
    .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack(s_ack), .gnt(gnt)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] dut_vec();
    return {gnt, s_cyc, s_stb, s_we, s_adr, s_dat_o,
            m0_ack, m0_err, m0_dat_i, m1_ack, m1_err, m1_dat_i};
  endfunction

  // ---------------- transfer-level reference model ----------------
  int own;    // master holding the bus, -1 when free
  int lastm;  // master that completed a transfer most recently
  int age;    // cycles the current transfer has waited for an ack

  function automatic void model_reset();
    own   = -1;
    lastm = 1;
    age   = 0;
  endfunction

  function automatic bit timed_out();
`ifdef WB_ARB_TIMEOUT_EN
    return (own >= 0) && (age == TB_TO - 1) && !s_ack && mcyc[own];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [OW-1:0] model_vec();
    logic [1:0]  g  = '0;
    logic        sc = 1'b0, ss = 1'b0, sw = 1'b0;
    logic [15:0] sa = '0, sd = '0;
    logic [1:0]  ak = '0, er = '0;
    logic [15:0] di [2];
    bit to;
    di[0] = '0;
    di[1] = '0;
    to = timed_out();
    if (own >= 0) begin
      g[own]  = 1'b1;
      sc      = mcyc[own] & ~to;
      ss      = mstb[own] & ~to;
      sw      = mwe[own];
      sa      = madr[own];
      sd      = mdat[own];
      ak[own] = s_ack;
      er[own] = to;
      di[own] = s_dat_i;
    end
    return {g, sc, ss, sw, sa, sd, ak[0], er[0], di[0], ak[1], er[1], di[1]};
  endfunction

  function automatic void model_update();
    bit to;
    logic [1:0] req;
    to  = timed_out();
    req = mcyc & mstb;
    if (own < 0) begin
      age = 0;
      if (req == 2'b11) own = 1 - lastm;
      else if (req[0])  own = 0;
      else if (req[1])  own = 1;
    end else if (s_ack || to) begin
      int o;
      o     = own;
      lastm = o;
      age   = 0;
      if (mlock[o] && req[o])   own = o;
      else if (req[1 - o])      own = 1 - o;
      else if (req[o])          own = o;
      else                      own = -1;
    end else if (!mcyc[own]) begin
      own = -1;
      age = 0;
    end else begin
      age++;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    mcyc = '0; mstb = '0; mwe = '0; mlock = '0;
    madr[0] = '0; madr[1] = '0; mdat[0] = '0; mdat[1] = '0;
    s_ack = 1'b0; s_dat_i = '0;
  endtask

  task automatic do_reset(input string name);
    clear_inputs();
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk(name, dut_vec(), '0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        c0, c1, l1, w1;
    logic [15:0] a0, a1, d1;
    logic        ack;
    logic [15:0] sdi;
    logic [1:0]  e_gnt;
    logic        e_stb, e_we;
    logic [15:0] e_adr, e_dout;
    logic        e_ack0;
    logic [15:0] e_di0;
    logic        e_ack1;
    logic [15:0] e_di1;
  } vec_t;

  function automatic vec_t row(
      logic c0, logic c1, logic l1, logic w1,
      logic [15:0] a0, logic [15:0] a1, logic [15:0] d1,
      logic ack, logic [15:0] sdi,
      logic [1:0] e_gnt, logic e_stb, logic e_we,
      logic [15:0] e_adr, logic [15:0] e_dout,
      logic e_ack0, logic [15:0] e_di0, logic e_ack1, logic [15:0] e_di1);
    vec_t v;
    v.c0 = c0; v.c1 = c1; v.l1 = l1; v.w1 = w1;
    v.a0 = a0; v.a1 = a1; v.d1 = d1; v.ack = ack; v.sdi = sdi;
    v.e_gnt = e_gnt; v.e_stb = e_stb; v.e_we = e_we;
    v.e_adr = e_adr; v.e_dout = e_dout;
    v.e_ack0 = e_ack0; v.e_di0 = e_di0; v.e_ack1 = e_ack1; v.e_di1 = e_di1;
    return v;
  endfunction

  localparam int unsigned NV = 19;
  vec_t tbl [NV];

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    model_reset();

    //            c0 c1 l1 w1  a0       a1       d1       ack sdi       gnt   stb we adr      dout     ak0 di0      ak1 di1
    tbl[0]  = row(1, 0, 0, 0, 16'h0010, 16'h0000, 16'h0000, 0, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    tbl[1]  = row(1, 0, 0, 0, 16'h0010, 16'h0000, 16'h0000, 1, 16'h6000, 2'b01, 1, 0, 16'h0010, 16'h1234, 1, 16'h6000, 0, 16'h0000);
    tbl[2]  = row(0, 0, 0, 0, 16'h0010, 16'h0000, 16'h0000, 0, 16'h0000, 2'b01, 0, 0, 16'h0010, 16'h1234, 0, 16'h0000, 0, 16'h0000);
    tbl[3]  = row(0, 0, 0, 0, 16'h0010, 16'h0000, 16'h0000, 0, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    tbl[4]  = row(1, 1, 0, 0, 16'h0020, 16'h0030, 16'hAAAA, 0, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    tbl[5]  = row(1, 1, 0, 0, 16'h0020, 16'h0030, 16'hAAAA, 1, 16'h5555, 2'b10, 1, 0, 16'h0030, 16'hAAAA, 0, 16'h0000, 1, 16'h5555);
    tbl[6]  = row(1, 1, 0, 0, 16'h0020, 16'h0030, 16'hAAAA, 0, 16'h0000, 2'b01, 1, 0, 16'h0020, 16'h1234, 0, 16'h0000, 0, 16'h0000);
    tbl[7]  = row(1, 1, 0, 0, 16'h0020, 16'h0030, 16'hAAAA, 1, 16'h0001, 2'b01, 1, 0, 16'h0020, 16'h1234, 1, 16'h0001, 0, 16'h0000);
    tbl[8]  = row(1, 1, 1, 1, 16'h0020, 16'h8000, 16'hBEEF, 1, 16'h0000, 2'b10, 1, 1, 16'h8000, 16'hBEEF, 0, 16'h0000, 1, 16'h0000);
    tbl[9]  = row(1, 1, 1, 1, 16'h0020, 16'h8000, 16'hBEEF, 1, 16'h0000, 2'b10, 1, 1, 16'h8000, 16'hBEEF, 0, 16'h0000, 1, 16'h0000);
    tbl[10] = row(1, 1, 1, 1, 16'h0020, 16'h8000, 16'hBEEF, 1, 16'h0000, 2'b10, 1, 1, 16'h8000, 16'hBEEF, 0, 16'h0000, 1, 16'h0000);
    tbl[11] = row(1, 1, 0, 1, 16'h0020, 16'h8000, 16'hBEEF, 0, 16'h0000, 2'b10, 1, 1, 16'h8000, 16'hBEEF, 0, 16'h0000, 0, 16'h0000);
    tbl[12] = row(1, 1, 0, 1, 16'h0020, 16'h8000, 16'hBEEF, 1, 16'h0002, 2'b10, 1, 1, 16'h8000, 16'hBEEF, 0, 16'h0000, 1, 16'h0002);
    tbl[13] = row(1, 1, 0, 0, 16'h0020, 16'h8000, 16'hBEEF, 0, 16'h0000, 2'b01, 1, 0, 16'h0020, 16'h1234, 0, 16'h0000, 0, 16'h0000);
    tbl[14] = row(0, 1, 0, 0, 16'h0020, 16'h0040, 16'h0B0B, 0, 16'h0000, 2'b01, 0, 0, 16'h0020, 16'h1234, 0, 16'h0000, 0, 16'h0000);
    tbl[15] = row(0, 1, 0, 0, 16'h0020, 16'h0040, 16'h0B0B, 1, 16'hFFFF, 2'b00, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    tbl[16] = row(0, 1, 0, 0, 16'h0020, 16'h0040, 16'h0B0B, 0, 16'h0000, 2'b10, 1, 0, 16'h0040, 16'h0B0B, 0, 16'h0000, 0, 16'h0000);
    tbl[17] = row(0, 0, 0, 0, 16'h0020, 16'h0040, 16'h0B0B, 0, 16'h0000, 2'b10, 0, 0, 16'h0040, 16'h0B0B, 0, 16'h0000, 0, 16'h0000);
    tbl[18] = row(0, 0, 0, 0, 16'h0020, 16'h0040, 16'h0B0B, 0, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000);

    // Directed table: single master, abort, round-robin, lock, idle ack
    do_reset("reset_state");
    for (int i = 0; i < int'(NV); i++) begin
      mcyc[0] = tbl[i].c0; mstb[0] = tbl[i].c0; mwe[0] = 1'b0; mlock[0] = 1'b0;
      madr[0] = tbl[i].a0; mdat[0] = 16'h1234;
      mcyc[1] = tbl[i].c1; mstb[1] = tbl[i].c1; mwe[1] = tbl[i].w1; mlock[1] = tbl[i].l1;
      madr[1] = tbl[i].a1; mdat[1] = tbl[i].d1;
      s_ack = tbl[i].ack; s_dat_i = tbl[i].sdi;
      @(negedge clk);
      chk($sformatf("table_row%0d", i), dut_vec(),
          {tbl[i].e_gnt, tbl[i].e_stb, tbl[i].e_stb, tbl[i].e_we, tbl[i].e_adr, tbl[i].e_dout,
           tbl[i].e_ack0, 1'b0, tbl[i].e_di0, tbl[i].e_ack1, 1'b0, tbl[i].e_di1});
      tick();
    end

    // Fairness from reset: m0 first, then alternate on every ack
    do_reset("reset_state2");
    mcyc = 2'b11; mstb = 2'b11;
    madr[0] = 16'h0100; madr[1] = 16'h0200;
    @(negedge clk);
    chk("rr_idle_gnt", OW'(gnt), OW'(2'b00));
    tick();
    for (int k = 0; k < 4; k++) begin
      logic [1:0] eg;
      eg = (k % 2 == 0) ? 2'b01 : 2'b10;
      s_ack = 1'b1; s_dat_i = 16'(k + 16'h0A00);
      @(negedge clk);
      chk($sformatf("rr_gnt%0d", k), OW'(gnt), OW'(eg));
      chk($sformatf("rr_model%0d", k), dut_vec(), model_vec());
      tick();
    end
    s_ack = 1'b0;
    @(negedge clk);
    chk("rr_after_gnt", OW'(gnt), OW'(2'b01));
    tick();

    // Asynchronous reset in the middle of a transfer
    do_reset("reset_state3");
    mcyc[0] = 1'b1; mstb[0] = 1'b1; madr[0] = 16'h0300;
    tick();
    @(negedge clk);
    chk("midrst_busy_stb", OW'(s_stb), OW'(1'b1));
    #2;
    s_ack = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("midrst_async_zero", OW'({s_cyc, s_stb, gnt, m0_ack, m0_err, m1_ack, m1_err}), '0);
    model_reset();
    s_ack = 1'b0;
    mcyc = 2'b11; mstb = 2'b11;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_release_idle", OW'(gnt), OW'(2'b00));
    tick();
    @(negedge clk);
    chk("midrst_m0_first", OW'(gnt), OW'(2'b01));
    tick();

`ifdef WB_ARB_TIMEOUT_EN
    // Hung slave: m1 terminated with err, pending m0 served next
    do_reset("reset_state4");
    mcyc[1] = 1'b1; mstb[1] = 1'b1; madr[1] = 16'h0400;
    tick();
    for (int i = 0; i < int'(TB_TO); i++) begin
      if (i == 3) begin
        mcyc[0] = 1'b1; mstb[0] = 1'b1;
      end
      @(negedge clk);
      chk($sformatf("wd_err%0d", i), OW'({m1_err, s_stb, m0_err}),
          OW'({(i == int'(TB_TO) - 1), (i != int'(TB_TO) - 1), 1'b0}));
      chk($sformatf("wd_model%0d", i), dut_vec(), model_vec());
      tick();
    end
    @(negedge clk);
    chk("wd_next_gnt", OW'({gnt, m1_err}), OW'({2'b01, 1'b0}));
    tick();
`endif

    // Randomized traffic against the model
    do_reset("reset_state5");
    for (int n = 0; n < 3000; n++) begin
      for (int m = 0; m < 2; m++) begin
        mcyc[m]  = ($urandom_range(0, 3) != 0);
        mstb[m]  = mcyc[m] & ($urandom_range(0, 9) != 0);
        mwe[m]   = 1'($urandom_range(0, 1));
        mlock[m] = ($urandom_range(0, 3) == 0);
        madr[m]  = 16'($urandom);
        mdat[m]  = 16'($urandom);
      end
      s_ack   = 1'($urandom_range(0, 1));
      s_dat_i = 16'($urandom);
      @(negedge clk);
      chk($sformatf("rand_cycle%0d", n), dut_vec(), model_vec());
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
